omega_io_port: RTL and testbench
================================

Name: omega_io_port

Overview:
- Synchronous IO-port front end for the oMega paged RAM expander.
- Samples the asynchronous Aquarius IORQ/WR/RD strobes in a single clock domain and glitch-filters them.
- Decodes writes to the page port and holds the LO/MID/HI page registers plus the HI RAM enable flag.
- Feeds the bank chip-enable/page-mux stage directly downstream, which consumes a_page/b_page/c_page/hi_ram_enable.

Parameters:
- IO_PORT, 8'hE7, IO address of the page port (compared against A7-A0).
- SYNC_STAGES, 2, flops in each input synchronizer; legal range 2..3.
- MIN_LOW, 2, consecutive qualified cycles a strobe must stay active before commit; legal range 1..15.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst_n  input  1  asynchronous active-low reset.
- aq_iorq_n  input  1  Aquarius IORQ, active low, asynchronous.
- aq_wr_n  input  1  Aquarius WR, active low, asynchronous.
- aq_rd_n  input  1  Aquarius RD, active low, asynchronous.
- aq_addr_lo  input  8  Aquarius A7-A0.
- aq_data_in  input  8  Aquarius data bus, input side.
- cart_present  input  1  high = cartridge inserted; asynchronous, synchronized internally.
- a_page  output  6  LO RAM page, $4000-$7FFF.
- b_page  output  6  MID RAM page, $8000-$BFFF.
- c_page  output  6  HI RAM page, $C000-$FFFF.
- hi_ram_enable  output  1  HI RAM may respond.
- page_upd  output  1  one-cycle pulse when a page register is written.
- upd_bank  output  2  bank code of the last update: 01 LO, 10 MID, 11 HI.
- aq_data_out  output  8  readback data (PAGE_READBACK_EN only; 0 otherwise).
- aq_data_oe  output  1  data bus drive enable (PAGE_READBACK_EN only; 0 otherwise).

Behaviour:
- Reset is asynchronous and active-low.
  - Clears all page registers, hi_ram_enable, page_upd, upd_bank, aq_data_out, aq_data_oe, and all synchronizer flops.
  - Flops reset to the inactive level: strobes 1, cart_present 0.
  - FSM returns to IDLE.
  - Reset mid-cycle aborts any pending commit; no partial update occurs.
- Synchronization and decode:
  - iorq, wr, rd, and cart_present each pass through SYNC_STAGES flops.
  - Address and data are sampled only while the FSM is in QUAL; they are stable because the strobes are already synchronized.
  - wr_hit = !iorq_s & !wr_s & (aq_addr_lo == IO_PORT).
- Write FSM, states IDLE, QUAL, COMMIT, WAIT_REL:
  - IDLE: on wr_hit go to QUAL with cnt=1.
  - QUAL:
    - If wr_hit drops, return to IDLE; glitch rejected, no update.
    - Otherwise capture aq_data_in into dlat and increment cnt.
    - When cnt reaches MIN_LOW, go to COMMIT.
  - COMMIT: lasts one cycle; applies dlat (see below), then goes to WAIT_REL.
  - WAIT_REL: stay while wr_hit; return to IDLE the first cycle it is low. One bus write produces exactly one commit.
- Commit rules on dlat[7:6]:
  - 00: no register change, no pulse.
  - 01: a_page <= dlat[5:0].
  - 10: b_page <= dlat[5:0].
  - 11: c_page <= dlat[5:0]; hi_ram_enable <= 1 if cart_present_s is 0.
  - Writes with bank code 01/10/11 pulse page_upd for the cycle after COMMIT and load upd_bank; registers are visible in the same cycle.
  - Latency: from strobe-low at the pin to register visible = SYNC_STAGES + MIN_LOW + 1 cycles.
- Cartridge priority:
  - While cart_present_s is 1, hi_ram_enable is forced to 0 on the next clock and cannot be set.
  - c_page still updates.
  - When the cartridge is removed, hi_ram_enable stays 0 until the next $C0-$FF write.
- Simultaneous cases:
  - A bus read and write cannot overlap on the Z80; if rd and wr are both sampled low, the write wins and the read is ignored.
  - A cart_present rise in the COMMIT cycle of a $Cx write: the clear wins.

Optional Feature:
- Macro: PAGE_READBACK_EN.
- Defined:
  - A read FSM (IDLE, QUAL, DRIVE) uses the same MIN_LOW qualification on !iorq_s & !rd_s & addr==IO_PORT.
  - In DRIVE: aq_data_oe=1 and aq_data_out={upd_bank, page of upd_bank}, or 8'h00 if no update has occurred since reset.
  - Returns to IDLE and drops oe the cycle after rd_s rises.
- Undefined: no read logic; aq_data_out=0 and aq_data_oe=0 constantly.

Decomposition:
- Package omega_pkg holds:
  - typedef bank_t (2 bits) with constants BANK_NONE=0, BANK_LO=1, BANK_MID=2, BANK_HI=3.
  - PAGE_W=6.
  - FSM state enum.
  - Default OMEGA_IO_PORT=8'hE7.
- One sub-module is natural: omega_sync_filter, a synchronizer plus MIN_LOW qualification counter, instantiated for the write and read strobes.

Test Plan:
- Reset, then OUT $E7,$45 with strobes low for 4 cycles -> a_page=5, page_upd single pulse, upd_bank=01; b_page, c_page, hi_ram_enable remain 0.
- OUT $E7,$BF then $C3 with cart_present=0 -> b_page=63, c_page=3, hi_ram_enable=1; with cart_present raised afterwards -> hi_ram_enable=0 within SYNC_STAGES+1 cycles.
- cart_present=1, OUT $E7,$C7 -> c_page=7, hi_ram_enable stays 0; OUT $E7,$12 -> no change and no page_upd.
- 1-cycle IORQ/WR glitch with MIN_LOW=2, and a write to port $E6 -> no register change, no page_upd.
- Strobe held low for 50 cycles -> exactly one page_upd; rst_n asserted during QUAL -> all outputs 0, no commit after release.
- With PAGE_READBACK_EN, after OUT $E7,$8A then IN $E7 -> aq_data_oe=1 and aq_data_out=$8A until RD rises.

Source files
------------

// File: rtl/omega_pkg.sv
// Shared types and constants for the oMega paged RAM expander IO port.
// Bank codes double as the top two data bits of a page-port write.
package omega_pkg;

    localparam int         PAGE_W        = 6;
    localparam logic [7:0] OMEGA_IO_PORT = 8'hE7;

    typedef logic [1:0] bank_t;

    localparam bank_t BANK_NONE = 2'd0;
    localparam bank_t BANK_LO   = 2'd1;
    localparam bank_t BANK_MID  = 2'd2;
    localparam bank_t BANK_HI   = 2'd3;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_QUAL,
        WR_COMMIT,
        WR_WAIT_REL
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_QUAL,
        RD_DRIVE
    } rd_state_t;

    function automatic logic [PAGE_W-1:0] page_of_bank(
        input bank_t             bank,
        input logic [PAGE_W-1:0] lo,
        input logic [PAGE_W-1:0] mid,
        input logic [PAGE_W-1:0] hi
    );
        case (bank)
            BANK_LO:  return lo;
            BANK_MID: return mid;
            BANK_HI:  return hi;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/omega_sync_filter.sv
// Synchronizes one IORQ/strobe pair and counts consecutive qualified cycles.
// Latency SYNC_STAGES cycles to hit; reached asserts once hit has held MIN_LOW-1 prior cycles.
module omega_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic iorq_n,
    input  logic strb_n,
    input  logic addr_hit,
    input  logic block,
    output logic hit,
    output logic reached
);

    localparam logic [3:0] QUAL_AT = 4'(MIN_LOW - 1);

    logic [SYNC_STAGES-1:0] iorq_q, iorq_d;
    logic [SYNC_STAGES-1:0] strb_q, strb_d;
    logic [3:0]             cnt_q, cnt_d;

    always_comb begin
        iorq_d  = {iorq_q[SYNC_STAGES-2:0], iorq_n};
        strb_d  = {strb_q[SYNC_STAGES-2:0], strb_n};
        // address is only trusted once both strobes have crossed the synchronizer
        hit     = !iorq_q[SYNC_STAGES-1] && !strb_q[SYNC_STAGES-1] && addr_hit && !block;
        cnt_d   = hit ? ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1) : 4'd0;
        reached = hit && (cnt_q >= QUAL_AT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iorq_q <= '1;
            strb_q <= '1;
            cnt_q  <= 4'd0;
        end else begin
            iorq_q <= iorq_d;
            strb_q <= strb_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/omega_io_port.sv
// oMega page-port front end: filtered IO writes load LO/MID/HI page registers and HI enable.
// Latency SYNC_STAGES+MIN_LOW+1 cycles pin-to-register; optional PAGE_READBACK_EN adds IN readback.
module omega_io_port
    import omega_pkg::*;
#(
    parameter logic [7:0] IO_PORT     = OMEGA_IO_PORT,
    parameter int         SYNC_STAGES = 2,
    parameter int         MIN_LOW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aq_iorq_n,
    input  logic              aq_wr_n,
    input  logic              aq_rd_n,
    input  logic [7:0]        aq_addr_lo,
    input  logic [7:0]        aq_data_in,
    input  logic              cart_present,
    output logic [PAGE_W-1:0] a_page,
    output logic [PAGE_W-1:0] b_page,
    output logic [PAGE_W-1:0] c_page,
    output logic              hi_ram_enable,
    output logic              page_upd,
    output logic [1:0]        upd_bank,
    output logic [7:0]        aq_data_out,
    output logic              aq_data_oe
);

    logic                   addr_hit;
    logic                   wr_hit, wr_reached;
    logic [SYNC_STAGES-1:0] cart_q, cart_d;
    logic                   cart_s;
    wr_state_t              wr_state_q, wr_state_d;
    logic [7:0]             dlat_q, dlat_d;
    logic [PAGE_W-1:0]      a_q, a_d, b_q, b_d, c_q, c_d;
    logic                   hi_q, hi_d, upd_q, upd_d;
    bank_t                  bank_q, bank_d;

    assign addr_hit = (aq_addr_lo == IO_PORT);
    assign cart_s   = cart_q[SYNC_STAGES-1];

    omega_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .MIN_LOW(MIN_LOW)) u_wr_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .iorq_n   (aq_iorq_n),
        .strb_n   (aq_wr_n),
        .addr_hit (addr_hit),
        .block    (1'b0),
        .hit      (wr_hit),
        .reached  (wr_reached)
    );

    always_comb begin
        cart_d     = {cart_q[SYNC_STAGES-2:0], cart_present};
        wr_state_d = wr_state_q;
        dlat_d     = dlat_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        // a present cartridge owns the HI window, including during a commit
        hi_d       = hi_q && !cart_s;
        upd_d      = 1'b0;
        bank_d     = bank_q;
        case (wr_state_q)
            WR_IDLE: if (wr_hit) wr_state_d = WR_QUAL;
            WR_QUAL: begin
                if (!wr_hit) begin
                    wr_state_d = WR_IDLE;
                end else begin
                    dlat_d = aq_data_in;
                    if (wr_reached) wr_state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                wr_state_d = WR_WAIT_REL;
                case (dlat_q[7:6])
                    BANK_LO:  a_d = dlat_q[PAGE_W-1:0];
                    BANK_MID: b_d = dlat_q[PAGE_W-1:0];
                    BANK_HI: begin
                        c_d  = dlat_q[PAGE_W-1:0];
                        hi_d = !cart_s;
                    end
                    default: ;
                endcase
                if (dlat_q[7:6] != BANK_NONE) begin
                    upd_d  = 1'b1;
                    bank_d = dlat_q[7:6];
                end
            end
            WR_WAIT_REL: if (!wr_hit) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cart_q     <= '0;
            wr_state_q <= WR_IDLE;
            dlat_q     <= 8'h00;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            hi_q       <= 1'b0;
            upd_q      <= 1'b0;
            bank_q     <= BANK_NONE;
        end else begin
            cart_q     <= cart_d;
            wr_state_q <= wr_state_d;
            dlat_q     <= dlat_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            hi_q       <= hi_d;
            upd_q      <= upd_d;
            bank_q     <= bank_d;
        end
    end

    assign a_page        = a_q;
    assign b_page        = b_q;
    assign c_page        = c_q;
    assign hi_ram_enable = hi_q;
    assign page_upd      = upd_q;
    assign upd_bank      = bank_q;

`ifdef PAGE_READBACK_EN
    logic      rd_hit, rd_reached;
    rd_state_t rd_state_q, rd_state_d;

    // a simultaneous write strobe suppresses the read
    omega_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .MIN_LOW(MIN_LOW)) u_rd_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .iorq_n   (aq_iorq_n),
        .strb_n   (aq_rd_n),
        .addr_hit (addr_hit),
        .block    (wr_hit),
        .hit      (rd_hit),
        .reached  (rd_reached)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE:  if (rd_hit) rd_state_d = RD_QUAL;
            RD_QUAL: begin
                if (!rd_hit)         rd_state_d = RD_IDLE;
                else if (rd_reached) rd_state_d = RD_DRIVE;
            end
            RD_DRIVE: if (!rd_hit) rd_state_d = RD_IDLE;
            default:  rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state_q <= RD_IDLE;
        else        rd_state_q <= rd_state_d;
    end

    assign aq_data_oe  = (rd_state_q == RD_DRIVE);
    assign aq_data_out = aq_data_oe ? {bank_q, page_of_bank(bank_q, a_q, b_q, c_q)} : 8'h00;
`else
    logic unused_rd_n;
    assign unused_rd_n = aq_rd_n;
    assign aq_data_oe  = 1'b0;
    assign aq_data_out = 8'h00;
`endif

endmodule

// File: tb/tb_omega_io_port.sv
// Directed bench for omega_io_port: expected page updates are queued at stimulus time and
// popped when page_upd pulses; register state is checked after each bus cycle.
module tb_omega_io_port;

    typedef struct {
        logic [1:0] bank;
        logic [5:0] page;
    } upd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       aq_iorq_n = 1'b1, aq_wr_n = 1'b1, aq_rd_n = 1'b1;
    logic [7:0] aq_addr_lo = 8'h00, aq_data_in = 8'h00;
    logic       cart_present = 1'b0;
    logic [5:0] a_page, b_page, c_page;
    logic       hi_ram_enable, page_upd, aq_data_oe;
    logic [1:0] upd_bank;
    logic [7:0] aq_data_out;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    upd_t sb[$];

    omega_io_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .aq_iorq_n     (aq_iorq_n),
        .aq_wr_n       (aq_wr_n),
        .aq_rd_n       (aq_rd_n),
        .aq_addr_lo    (aq_addr_lo),
        .aq_data_in    (aq_data_in),
        .cart_present  (cart_present),
        .a_page        (a_page),
        .b_page        (b_page),
        .c_page        (c_page),
        .hi_ram_enable (hi_ram_enable),
        .page_upd      (page_upd),
        .upd_bank      (upd_bank),
        .aq_data_out   (aq_data_out),
        .aq_data_oe    (aq_data_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] page_of(input logic [1:0] bank);
        case (bank)
            2'd1:    return a_page;
            2'd2:    return b_page;
            2'd3:    return c_page;
            default: return 6'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && page_upd) begin
            upd_t e;
            pulses++;
            chk("upd_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("upd_bank", {30'd0, upd_bank}, {30'd0, e.bank});
                chk("upd_page", {26'd0, page_of(e.bank)}, {26'd0, e.page});
            end
        end
    end

    // Drives one OUT cycle; lat = negedges from strobe assertion to first page_upd (0 if none).
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                            input int low_cyc, output int lat);
        aq_addr_lo = addr;
        aq_data_in = data;
        aq_iorq_n  = 1'b0;
        aq_wr_n    = 1'b0;
        lat        = 0;
        for (int i = 1; i <= low_cyc + 12; i++) begin
            @(negedge clk);
            if (page_upd && lat == 0) lat = i;
            if (i == low_cyc) begin
                aq_iorq_n = 1'b1;
                aq_wr_n   = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [7:0] data);
        upd_t e;
        e.bank = data[7:6];
        e.page = data[5:0];
        sb.push_back(e);
    endtask

    initial begin
        int lat;
        int p0;
        repeat (3) @(negedge clk);
        chk("rst_a_page", {26'd0, a_page}, 32'd0);
        chk("rst_b_page", {26'd0, b_page}, 32'd0);
        chk("rst_c_page", {26'd0, c_page}, 32'd0);
        chk("rst_hi_en", {31'd0, hi_ram_enable}, 32'd0);
        chk("rst_page_upd", {31'd0, page_upd}, 32'd0);
        chk("rst_upd_bank", {30'd0, upd_bank}, 32'd0);
        chk("rst_data_out", {24'd0, aq_data_out}, 32'd0);
        chk("rst_data_oe", {31'd0, aq_data_oe}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LO write: SYNC_STAGES(2) + MIN_LOW(2) + 1 = 5 cycles to visible
        push(8'h45);
        io_write(8'hE7, 8'h45, 4, lat);
        chk("lo_latency", lat, 32'd5);
        chk("lo_a_page", {26'd0, a_page}, 32'd5);
        chk("lo_b_page", {26'd0, b_page}, 32'd0);
        chk("lo_c_page", {26'd0, c_page}, 32'd0);
        chk("lo_hi_en", {31'd0, hi_ram_enable}, 32'd0);
        chk("lo_upd_bank", {30'd0, upd_bank}, 32'd1);

        push(8'hBF);
        io_write(8'hE7, 8'hBF, 4, lat);
        push(8'hC3);
        io_write(8'hE7, 8'hC3, 4, lat);
        chk("mid_b_page", {26'd0, b_page}, 32'd63);
        chk("hi_c_page", {26'd0, c_page}, 32'd3);
        chk("hi_en_set", {31'd0, hi_ram_enable}, 32'd1);

        // cartridge insertion clears HI enable one clock after it synchronizes
        cart_present = 1'b1;
        repeat (2) @(negedge clk);
        chk("cart_hi_en_2", {31'd0, hi_ram_enable}, 32'd1);
        @(negedge clk);
        chk("cart_hi_en_3", {31'd0, hi_ram_enable}, 32'd0);

        push(8'hC7);
        io_write(8'hE7, 8'hC7, 4, lat);
        chk("cart_c_page", {26'd0, c_page}, 32'd7);
        chk("cart_hi_blocked", {31'd0, hi_ram_enable}, 32'd0);

        io_write(8'hE7, 8'h12, 4, lat);
        chk("nobank_no_pulse", lat, 32'd0);
        chk("nobank_a_page", {26'd0, a_page}, 32'd5);
        chk("nobank_b_page", {26'd0, b_page}, 32'd63);
        chk("nobank_c_page", {26'd0, c_page}, 32'd7);

        io_write(8'hE7, 8'h41, 1, lat);
        chk("glitch_no_pulse", lat, 32'd0);
        chk("glitch_a_page", {26'd0, a_page}, 32'd5);
        io_write(8'hE6, 8'h42, 4, lat);
        chk("port_e6_no_pulse", lat, 32'd0);
        chk("port_e6_a_page", {26'd0, a_page}, 32'd5);

        cart_present = 1'b0;
        repeat (5) @(negedge clk);
        chk("cart_removed_hi_en", {31'd0, hi_ram_enable}, 32'd0);

        p0 = pulses;
        push(8'hC9);
        io_write(8'hE7, 8'hC9, 50, lat);
        chk("long_one_pulse", pulses - p0, 32'd1);
        chk("long_c_page", {26'd0, c_page}, 32'd9);
        chk("long_hi_en", {31'd0, hi_ram_enable}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        // reset while the FSM is qualifying a write
        p0 = pulses;
        aq_addr_lo = 8'hE7;
        aq_data_in = 8'h44;
        aq_iorq_n  = 1'b0;
        aq_wr_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_a_page", {26'd0, a_page}, 32'd0);
        chk("midrst_c_page", {26'd0, c_page}, 32'd0);
        chk("midrst_hi_en", {31'd0, hi_ram_enable}, 32'd0);
        chk("midrst_upd_bank", {30'd0, upd_bank}, 32'd0);
        aq_iorq_n = 1'b1;
        aq_wr_n   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("midrst_no_commit", pulses - p0, 32'd0);
        chk("midrst_a_after", {26'd0, a_page}, 32'd0);

`ifdef PAGE_READBACK_EN
        begin
            int n;
            push(8'h8A);
            io_write(8'hE7, 8'h8A, 4, lat);
            aq_addr_lo = 8'hE7;
            aq_iorq_n  = 1'b0;
            aq_rd_n    = 1'b0;
            n = 0;
            for (int i = 0; i < 20 && !aq_data_oe; i++) begin
                @(negedge clk);
                n++;
            end
            chk("rb_oe", {31'd0, aq_data_oe}, 32'd1);
            chk("rb_data", {24'd0, aq_data_out}, 32'h8A);
            repeat (5) @(negedge clk);
            chk("rb_oe_hold", {31'd0, aq_data_oe}, 32'd1);
            chk("rb_data_hold", {24'd0, aq_data_out}, 32'h8A);
            aq_iorq_n = 1'b1;
            aq_rd_n   = 1'b1;
            n = 0;
            for (int i = 0; i < 10 && aq_data_oe; i++) begin
                @(negedge clk);
                n++;
            end
            chk("rb_oe_drop", {31'd0, aq_data_oe}, 32'd0);
            chk("rb_drop_cycles", n, 32'd3);
        end
`endif

        repeat (3) @(negedge clk);
        chk("sb_final_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
